// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding APB3 initiator.
// A CPU-side request is decoded to one slave by its upper address bits and run
// through SETUP and ACCESS with wait-state and timeout handling. Read data and
// an error flag come back on a valid/ready response channel.
module apb_master_bridge #(
    parameter int ADDR_W   = 8,
    parameter int SLV_BITS = 2,
    parameter int TIMEOUT  = 16
) (
    input  logic                            apb_pclk,
    input  logic                            apb_prstn,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [ADDR_W-1:0]               req_addr,
    input  logic                            req_write,
    input  logic [31:0]                     req_wdata,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [31:0]                     rsp_rdata,
    output logic                            rsp_err,
    output logic [(2**SLV_BITS)-1:0]        apb_psel,
    output logic [ADDR_W-SLV_BITS-1:0]      apb_paddr,
    output logic                            apb_pwrite,
    output logic                            apb_penable,
    output logic [31:0]                     apb_pwdata,
    input  logic [32*(2**SLV_BITS)-1:0]     apb_prdata,
    input  logic [(2**SLV_BITS)-1:0]        apb_pready,
    input  logic [(2**SLV_BITS)-1:0]        apb_pslverr
);

    localparam int NSLV  = 2**SLV_BITS;
    localparam int CNT_W = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;

    logic [SLV_BITS-1:0]        r_idx,       w_idx_nxt;
    logic [CNT_W-1:0]           r_cnt,       w_cnt_nxt;
    logic [NSLV-1:0]            r_psel,      w_psel_nxt;
    logic                       r_penable,   w_penable_nxt;
    logic [ADDR_W-SLV_BITS-1:0] r_paddr,     w_paddr_nxt;
    logic                       r_pwrite,    w_pwrite_nxt;
    logic [31:0]                r_pwdata,    w_pwdata_nxt;
    logic                       r_rsp_valid, w_rsp_valid_nxt;
    logic [31:0]                r_rdata,     w_rdata_nxt;
    logic                       r_err,       w_err_nxt;

    logic [31:0]                w_sel_prdata;
    logic                       w_sel_pready;
    logic                       w_sel_pslverr;
    logic                       w_timeout;

    // Only the latched slave's return signals are looked at; the rest are ignored.
    always_comb begin
        w_sel_prdata  = '0;
        w_sel_pready  = 1'b0;
        w_sel_pslverr = 1'b0;
        for (int k = 0; k < NSLV; k++) begin
            if (r_idx == SLV_BITS'(k)) begin
                w_sel_prdata  = apb_prdata[32*k +: 32];
                w_sel_pready  = apb_pready[k];
                w_sel_pslverr = apb_pslverr[k];
            end
        end
    end

    // The counter sits at TIMEOUT-1 during the last ACCESS cycle a slave is allowed.
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

    // Request acceptance is decoded from state and suppressed while in reset.
    assign req_ready = apb_prstn && (r_state == S_IDLE);

    // State register.
    always_ff @(posedge apb_pclk) begin
        if (!apb_prstn) r_state <= S_IDLE;
        else            r_state <= w_state_nxt;
    end

    // Next-state decode: SETUP is always one cycle, ACCESS ends on pready or timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (req_valid)                  w_state_nxt = S_SETUP;
            S_SETUP:                                  w_state_nxt = S_ACCESS;
            S_ACCESS: if (w_sel_pready || w_timeout)  w_state_nxt = S_RESP;
            S_RESP:   if (rsp_ready)                  w_state_nxt = S_IDLE;
            default:                                  w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: next values for every registered output, keyed on the next state.
    always_comb begin
        w_idx_nxt    = r_idx;
        w_paddr_nxt  = r_paddr;
        w_pwrite_nxt = r_pwrite;
        w_pwdata_nxt = r_pwdata;
        w_cnt_nxt    = r_cnt;
        w_rdata_nxt  = r_rdata;
        w_err_nxt    = r_err;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_idx_nxt    = req_addr[ADDR_W-1 -: SLV_BITS];
                    w_paddr_nxt  = req_addr[ADDR_W-SLV_BITS-1:0];
                    w_pwrite_nxt = req_write;
                    w_pwdata_nxt = req_wdata;
                end
            end
            S_SETUP: w_cnt_nxt = '0;
            S_ACCESS: begin
                if (w_sel_pready) begin
                    w_rdata_nxt = r_pwrite ? 32'h0 : w_sel_prdata;
                    w_err_nxt   = w_sel_pslverr;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (w_timeout) begin
                        w_rdata_nxt = 32'h0;
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        w_psel_nxt = '0;
        if (w_state_nxt == S_SETUP || w_state_nxt == S_ACCESS) begin
            for (int k = 0; k < NSLV; k++) w_psel_nxt[k] = (w_idx_nxt == SLV_BITS'(k));
        end
        w_penable_nxt   = (w_state_nxt == S_ACCESS);
        w_rsp_valid_nxt = (w_state_nxt == S_RESP);
    end

    // Output and transaction registers; every one clears on reset so a dropped transfer leaves no trace.
    always_ff @(posedge apb_pclk) begin
        if (!apb_prstn) begin
            r_idx       <= '0;
            r_cnt       <= '0;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_idx       <= w_idx_nxt;
            r_cnt       <= w_cnt_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rdata     <= w_rdata_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign apb_psel    = r_psel;
    assign apb_penable = r_penable;
    assign apb_paddr   = r_paddr;
    assign apb_pwrite  = r_pwrite;
    assign apb_pwdata  = r_pwdata;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rdata;
    assign rsp_err     = r_err;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Testbench for apb_master_bridge: directed vector table, hand sequences for
// back-to-back/reset corners, and randomized transactions against a spec model.
module tb_apb_master_bridge;

    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rstn;
    logic         req_valid;
    logic         req_ready;
    logic [7:0]   req_addr;
    logic         req_write;
    logic [31:0]  req_wdata;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [31:0]  rsp_rdata;
    logic         rsp_err;
    logic [3:0]   psel;
    logic [5:0]   paddr;
    logic         pwrite;
    logic         penable;
    logic [31:0]  pwdata;
    logic [127:0] prdata;
    logic [3:0]   pready;
    logic [3:0]   pslverr;

    always #5 clk = ~clk;

    apb_master_bridge #(.ADDR_W(8), .SLV_BITS(2), .TIMEOUT(TO)) dut (
        .apb_pclk    (clk),
        .apb_prstn   (rstn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_write   (req_write),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .apb_psel    (psel),
        .apb_paddr   (paddr),
        .apb_pwrite  (pwrite),
        .apb_penable (penable),
        .apb_pwdata  (pwdata),
        .apb_prdata  (prdata),
        .apb_pready  (pready),
        .apb_pslverr (pslverr)
    );

    typedef struct {
        logic [7:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        int          waits;
        logic        serr;
        logic [31:0] sdata;
        int          stall;
        logic [3:0]  exp_psel;
        logic [5:0]  exp_paddr;
        int          exp_len;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected outcome of one transaction from the protocol rules alone.
    function automatic vec_t model(input vec_t v);
        vec_t m;
        bit   to;
        m  = v;
        to = (v.waits >= TO);
        m.exp_psel  = 4'b0001 << v.addr[7:6];
        m.exp_paddr = v.addr[5:0];
        m.exp_len   = to ? TO : v.waits + 1;
        m.exp_err   = to ? 1'b1 : v.serr;
        m.exp_rdata = (to || v.wr) ? 32'h0 : v.sdata;
        return m;
    endfunction

    task automatic wait_req_ready();
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_ready_wait", req_ready, 1);
    endtask

    // Runs one request end to end, acting as the slave; entered and left just after a posedge.
    task automatic run_txn(input vec_t v);
        int idx;
        int len;
        idx = int'(v.addr[7:6]);
        rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            prdata[32*k +: 32] = $urandom;
            pslverr[k]         = 1'($urandom);
            pready[k]          = 1'($urandom);
        end
        prdata[32*idx +: 32] = v.sdata;
        pslverr[idx]         = v.serr;
        pready[idx]          = 1'b0;
        wait_req_ready();
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_write = v.wr;
        req_wdata = v.wdata;
        @(negedge clk);
        chk("hs_req_ready", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = 8'($urandom);
        req_write = 1'($urandom);
        req_wdata = $urandom;
        @(negedge clk);
        chk("setup_psel", psel, v.exp_psel);
        chk("setup_penable", penable, 0);
        chk("setup_paddr", paddr, v.exp_paddr);
        chk("setup_pwrite", pwrite, v.wr);
        chk("setup_pwdata", pwdata, v.wdata);
        chk("setup_rsp_valid", rsp_valid, 0);
        chk("setup_req_ready", req_ready, 0);
        len = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            pready[idx] = (len >= v.waits);
            for (int k = 0; k < 4; k++) begin
                if (k != idx) begin
                    pready[k]  = 1'($urandom);
                    pslverr[k] = 1'($urandom);
                end
            end
            @(negedge clk);
            if (!penable) break;
            len++;
            chk("acc_psel", psel, v.exp_psel);
            chk("acc_paddr", paddr, v.exp_paddr);
            chk("acc_pwrite", pwrite, v.wr);
            chk("acc_pwdata", pwdata, v.wdata);
            chk("acc_rsp_valid", rsp_valid, 0);
        end
        chk("acc_len", len, v.exp_len);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("rsp_err", rsp_err, v.exp_err);
        chk("rsp_psel", psel, 0);
        chk("rsp_penable", penable, 0);
        chk("rsp_req_ready", req_ready, 0);
        for (int s = 0; s < v.stall; s++) begin
            @(posedge clk); #1;
            pready[idx]          = 1'b1;
            pslverr[idx]         = ~v.serr;
            prdata[32*idx +: 32] = ~v.sdata;
            @(negedge clk);
            chk("stall_rsp_valid", rsp_valid, 1);
            chk("stall_rdata", rsp_rdata, v.exp_rdata);
            chk("stall_err", rsp_err, v.exp_err);
            chk("stall_psel", psel, 0);
            chk("stall_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("done_rsp_valid", rsp_valid, 0);
        chk("done_req_ready", req_ready, 1);
        chk("done_psel", psel, 0);
        @(posedge clk); #1;
    endtask

    vec_t tbl[7];
    vec_t rv;
    int   n;

    initial begin
        //           addr   wr    wdata         waits serr  sdata         stall psel     paddr  len rdata         err
        tbl[0] = '{8'h44, 1'b0, 32'h00000000,   0, 1'b0, 32'hDEADBEEF, 0, 4'b0010, 6'h04,  1, 32'hDEADBEEF, 1'b0};
        tbl[1] = '{8'h08, 1'b1, 32'h12345678,   3, 1'b0, 32'h11111111, 1, 4'b0001, 6'h08,  4, 32'h00000000, 1'b0};
        tbl[2] = '{8'h80, 1'b0, 32'h00000000, 100, 1'b0, 32'h22222222, 2, 4'b0100, 6'h00, 16, 32'h00000000, 1'b1};
        tbl[3] = '{8'hFC, 1'b0, 32'h00000000,   1, 1'b1, 32'hCAFEF00D, 0, 4'b1000, 6'h3C,  2, 32'hCAFEF00D, 1'b1};
        tbl[4] = '{8'hA5, 1'b0, 32'h00000000,  15, 1'b0, 32'h0BADF00D, 0, 4'b0100, 6'h25, 16, 32'h0BADF00D, 1'b0};
        tbl[5] = '{8'h7F, 1'b1, 32'h55AA55AA,  16, 1'b0, 32'h33333333, 0, 4'b0010, 6'h3F, 16, 32'h00000000, 1'b1};
        tbl[6] = '{8'h40, 1'b1, 32'hCAFEBABE,   0, 1'b1, 32'h44444444, 5, 4'b0010, 6'h00,  1, 32'h00000000, 1'b1};

        rstn      = 1'b0;
        req_valid = 1'b0;
        req_addr  = 8'h0;
        req_write = 1'b0;
        req_wdata = 32'h0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = '0;
        pslverr   = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("rel_req_ready", req_ready, 1);
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 7; i++) run_txn(tbl[i]);

        // Back-to-back with response stall
        pready    = 4'hF;
        pslverr   = 4'h0;
        prdata    = {32'h33330003, 32'h22220002, 32'h11110001, 32'hAAAA0000};
        rsp_ready = 1'b0;
        wait_req_ready();
        req_valid = 1'b1;
        req_addr  = 8'h10;
        req_write = 1'b0;
        @(posedge clk); #1;
        req_addr  = 8'hC8;
        req_write = 1'b1;
        req_wdata = 32'h0F0F0F0F;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 10) begin
            chk("b2b_blocked", req_ready, 0);
            @(negedge clk);
            n++;
        end
        chk("b2b_rsp1_valid", rsp_valid, 1);
        chk("b2b_rsp1_rdata", rsp_rdata, 32'hAAAA0000);
        chk("b2b_rsp1_err", rsp_err, 0);
        for (int s = 0; s < 5; s++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("b2b_stall_ready", req_ready, 0);
            chk("b2b_stall_valid", rsp_valid, 1);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("b2b_ready_after", req_ready, 1);
        chk("b2b_valid_after", rsp_valid, 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_setup_psel", psel, 4'b1000);
        chk("b2b_setup_penable", penable, 0);
        chk("b2b_setup_paddr", paddr, 6'h08);
        chk("b2b_setup_pwrite", pwrite, 1);
        chk("b2b_setup_pwdata", pwdata, 32'h0F0F0F0F);
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_rsp2_valid", rsp_valid, 1);
        chk("b2b_rsp2_rdata", rsp_rdata, 0);
        chk("b2b_rsp2_err", rsp_err, 0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        // Reset during an ACCESS wait state
        pready  = 4'h0;
        pslverr = 4'h0;
        wait_req_ready();
        req_valid = 1'b1;
        req_addr  = 8'h08;
        req_write = 1'b1;
        req_wdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_penable", penable, 1);
        chk("mid_pwdata", pwdata, 32'hA5A5A5A5);
        rstn = 1'b0;
        #1;
        chk("mid_rst_req_ready", req_ready, 0);
        @(posedge clk); #1;
        chk("mid_rst_psel", psel, 0);
        chk("mid_rst_penable", penable, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_pwdata", pwdata, 0);
        chk("mid_rst_paddr", paddr, 0);
        chk("mid_rst_pwrite", pwrite, 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("mid_rel_req_ready", req_ready, 1);
        chk("mid_rel_rsp_valid", rsp_valid, 0);
        @(posedge clk); #1;
        run_txn(tbl[0]);

        // Randomized transactions against the model
        for (int i = 0; i < 40; i++) begin
            rv.addr  = 8'($urandom);
            rv.wr    = 1'($urandom);
            rv.wdata = $urandom;
            rv.serr  = 1'($urandom);
            rv.sdata = $urandom;
            rv.stall = $urandom_range(0, 3);
            rv.waits = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 3);
            rv = model(rv);
            run_txn(rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
